// File: rtl/paula_audio_pkg.sv
// Shared constants, the channel index type and the volume clamp used by the
// Paula audio volume sequencer.
package paula_audio_pkg;

    localparam int NCH       = 4;
    localparam int SAMPW     = 8;
    localparam int VOLW      = 7;
    localparam int VOL_UNITY = 64;
    localparam int VOL_SHIFT = 6;
    // Signed sample times unsigned volume: 8 + 7 bits.
    localparam int PRODW     = SAMPW + VOLW;

    typedef logic [1:0] chan_t;

    // Volumes above unity are treated as unity, which keeps every product
    // within -8192..8128 so the shifted result always fits in 8 bits.
    function automatic logic [VOLW-1:0] clamp_vol(input logic [VOLW-1:0] v);
        if (v > VOLW'(VOL_UNITY)) begin
            return VOLW'(VOL_UNITY);
        end
        return v;
    endfunction

endpackage

// File: rtl/paula_audio_rr_arb.sv
// Combinational 4-way round-robin search: returns the first set request bit
// found when scanning circularly upward from ptr. The parent owns the pointer.
module paula_audio_rr_arb
    import paula_audio_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  chan_t          ptr,
    output logic           gnt_valid,
    output chan_t          gnt_idx
);

    // Scan ptr, ptr+1, ... (mod 4) and keep the first hit.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!gnt_valid && req[ptr + chan_t'(k)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = ptr + chan_t'(k);
            end
        end
    end

endmodule

// File: rtl/paula_audio_volume_sequencer.sv
// Applies per-channel volume to the four Paula audio samples using one shared
// signed 8x7 multiplier. A two-stage pipeline (grant/multiply, writeback)
// advances on every colour-clock tick, servicing one channel per tick.
module paula_audio_volume_sequencer
    import paula_audio_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk7_en,
    input  logic             cck,
    input  logic [SAMPW-1:0] sample0,
    input  logic [SAMPW-1:0] sample1,
    input  logic [SAMPW-1:0] sample2,
    input  logic [SAMPW-1:0] sample3,
    input  logic [VOLW-1:0]  vol0,
    input  logic [VOLW-1:0]  vol1,
    input  logic [VOLW-1:0]  vol2,
    input  logic [VOLW-1:0]  vol3,
    input  logic [NCH-1:0]   ch_load,
    input  logic             overrun_clr,
    output logic [SAMPW-1:0] osample0,
    output logic [SAMPW-1:0] osample1,
    output logic [SAMPW-1:0] osample2,
    output logic [SAMPW-1:0] osample3,
    output logic             out_strobe,
    output logic [NCH-1:0]   pending,
    output logic [NCH-1:0]   overrun
);

    logic [SAMPW-1:0] sample_in [NCH];
    logic [VOLW-1:0]  vol_in    [NCH];

    logic [SAMPW-1:0] hold_s_q  [NCH];
    logic [VOLW-1:0]  hold_v_q  [NCH];
    logic [NCH-1:0]   pending_q, pending_d;
    logic [NCH-1:0]   overrun_q, overrun_d;
    chan_t            rr_ptr_q;
    logic             mul_valid_q;
    chan_t            mul_ch_q;
    logic signed [PRODW-1:0] prod_q, prod_d;
    logic [SAMPW-1:0] osample_q [NCH];
    logic             out_strobe_q;

    logic             tick;
    logic             grant;
    logic             gnt_valid;
    chan_t            gnt_idx;
    logic [NCH-1:0]   load_mask;
    logic [NCH-1:0]   grant_mask;
    logic [SAMPW-1:0] wb_val;

    assign sample_in[0] = sample0;
    assign sample_in[1] = sample1;
    assign sample_in[2] = sample2;
    assign sample_in[3] = sample3;
    assign vol_in[0]    = vol0;
    assign vol_in[1]    = vol1;
    assign vol_in[2]    = vol2;
    assign vol_in[3]    = vol3;

    paula_audio_rr_arb u_arb (
        .req       (pending_q),
        .ptr       (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Next-state for pending/overrun and the product of the granted channel.
    // A load on the channel being granted re-arms pending without flagging an
    // overrun, because the old value is consumed by this very grant.
    always_comb begin
        tick       = clk7_en & cck;
        grant      = tick & gnt_valid;
        load_mask  = ch_load & {NCH{clk7_en}};
        grant_mask = grant ? (NCH'(1) << gnt_idx) : '0;

        pending_d  = (pending_q & ~grant_mask) | load_mask;
        overrun_d  = (overrun_q & ~{NCH{overrun_clr}})
                   | (load_mask & pending_q & ~grant_mask);

        prod_d     = $signed({{(PRODW-SAMPW){hold_s_q[gnt_idx][SAMPW-1]}}, hold_s_q[gnt_idx]})
                   * $signed({{(PRODW-VOLW){1'b0}}, hold_v_q[gnt_idx]});

        // Arithmetic shift floors toward minus infinity; the result always
        // fits in 8 bits because volume never exceeds unity.
        wb_val     = SAMPW'(prod_q >>> VOL_SHIFT);
    end

    // Capture loaded samples and clamped volumes into the holding registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                hold_s_q[i] <= '0;
                hold_v_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (load_mask[i]) begin
                    hold_s_q[i] <= sample_in[i];
                    hold_v_q[i] <= clamp_vol(vol_in[i]);
                end
            end
        end
    end

    // Pending and sticky overrun flags update every clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Grant/multiply stage: advances only on a tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            mul_valid_q <= 1'b0;
            mul_ch_q    <= '0;
            prod_q      <= '0;
        end else if (tick) begin
            mul_valid_q <= gnt_valid;
            if (gnt_valid) begin
                rr_ptr_q <= gnt_idx + chan_t'(1);
                mul_ch_q <= gnt_idx;
                prod_q   <= prod_d;
            end
        end
    end

    // Writeback stage: update one output on a tick after a grant, pulse strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                osample_q[i] <= '0;
            end
            out_strobe_q <= 1'b0;
        end else begin
            out_strobe_q <= 1'b0;
            if (tick && mul_valid_q) begin
                osample_q[mul_ch_q] <= wb_val;
                out_strobe_q        <= 1'b1;
            end
        end
    end

    assign osample0   = osample_q[0];
    assign osample1   = osample_q[1];
    assign osample2   = osample_q[2];
    assign osample3   = osample_q[3];
    assign out_strobe = out_strobe_q;
    assign pending    = pending_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_paula_audio_volume_sequencer.sv
// Directed bench for the Paula audio volume sequencer.
module tb_paula_audio_volume_sequencer;

    logic       clk;
    logic       reset_n;
    logic       clk7_en;
    logic       cck;
    logic [7:0] sample0, sample1, sample2, sample3;
    logic [6:0] vol0, vol1, vol2, vol3;
    logic [3:0] ch_load;
    logic       overrun_clr;
    logic [7:0] osample0, osample1, osample2, osample3;
    logic       out_strobe;
    logic [3:0] pending;
    logic [3:0] overrun;

    int checks   = 0;
    int failures = 0;

    paula_audio_volume_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk7_en     (clk7_en),
        .cck         (cck),
        .sample0     (sample0),
        .sample1     (sample1),
        .sample2     (sample2),
        .sample3     (sample3),
        .vol0        (vol0),
        .vol1        (vol1),
        .vol2        (vol2),
        .vol3        (vol3),
        .ch_load     (ch_load),
        .overrun_clr (overrun_clr),
        .osample0    (osample0),
        .osample1    (osample1),
        .osample2    (osample2),
        .osample3    (osample3),
        .out_strobe  (out_strobe),
        .pending     (pending),
        .overrun     (overrun)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] osamp(input int ch);
        case (ch)
            0:       return osample0;
            1:       return osample1;
            2:       return osample2;
            default: return osample3;
        endcase
    endfunction

    task automatic set_chan(input int ch, input logic [7:0] s, input logic [6:0] v);
        case (ch)
            0:       begin sample0 = s; vol0 = v; end
            1:       begin sample1 = s; vol1 = v; end
            2:       begin sample2 = s; vol2 = v; end
            default: begin sample3 = s; vol3 = v; end
        endcase
    endtask

    // One clock with the given enables/loads; returns 1 time unit after the edge.
    task automatic step(input logic en, input logic c, input logic [3:0] ld);
        clk7_en = en;
        cck     = c;
        ch_load = ld;
        @(posedge clk);
        #1;
        clk7_en     = 1'b0;
        cck         = 1'b0;
        ch_load     = 4'h0;
        overrun_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clk7_en = 1'b0; cck = 1'b0; ch_load = 4'h0; overrun_clr = 1'b0;
        for (int i = 0; i < 4; i++) set_chan(i, 8'h00, 7'd0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (osamp(i) !== 8'h00) begin
                failures++;
                $display("FAIL reset_osample%0d got=%h exp=00", i, osamp(i));
            end
        end
        checks++;
        if ({out_strobe, pending, overrun} !== 9'h000) begin
            failures++;
            $display("FAIL reset_flags got strobe=%b pending=%h overrun=%h exp 0/0/0",
                     out_strobe, pending, overrun);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_all();
        logic [7:0] exp_s [4];
        exp_s[0] = 8'h40; exp_s[1] = 8'h80; exp_s[2] = 8'h7F; exp_s[3] = 8'hFF;
        for (int i = 0; i < 4; i++) set_chan(i, exp_s[i], 7'd64);
        step(1'b1, 1'b1, 4'hF);
        checks++;
        if (pending !== 4'hF) begin
            failures++;
            $display("FAIL load_all_pending got=%h exp=f", pending);
        end
        step(1'b1, 1'b1, 4'h0);   // grant ch0
        checks++;
        if (pending !== 4'hE || out_strobe !== 1'b0) begin
            failures++;
            $display("FAIL load_all_grant0 got pending=%h strobe=%b exp e/0", pending, out_strobe);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 4'h0);
            checks++;
            if (osamp(i) !== exp_s[i] || out_strobe !== 1'b1) begin
                failures++;
                $display("FAIL load_all_wb%0d got=%h strobe=%b exp=%h strobe=1",
                         i, osamp(i), out_strobe, exp_s[i]);
            end
        end
        // Non-tick clock: strobe drops and outputs hold.
        step(1'b0, 1'b0, 4'h0);
        checks++;
        if (out_strobe !== 1'b0 || pending !== 4'h0 || osample3 !== 8'hFF) begin
            failures++;
            $display("FAIL load_all_idle got strobe=%b pending=%h os3=%h exp 0/0/ff",
                     out_strobe, pending, osample3);
        end
    endtask

    task automatic run_one(input string name, input int ch, input logic [7:0] s,
                           input logic [6:0] v, input logic [7:0] exp_val);
        set_chan(ch, s, v);
        step(1'b1, 1'b1, 4'(1 << ch));
        step(1'b1, 1'b1, 4'h0);
        step(1'b1, 1'b1, 4'h0);
        checks++;
        if (osamp(ch) !== exp_val || out_strobe !== 1'b1) begin
            failures++;
            $display("FAIL %s got=%h strobe=%b exp=%h strobe=1", name, osamp(ch), out_strobe, exp_val);
        end
    endtask

    task automatic test_scaling();
        run_one("scale_7f_v32", 0, 8'h7F, 7'd32, 8'h3F);
        run_one("scale_81_v32", 0, 8'h81, 7'd32, 8'hC0);
        run_one("scale_v0",     0, 8'h55, 7'd0,  8'h00);
        run_one("clamp_v127",   1, 8'h80, 7'd127, 8'h80);
        run_one("clamp_v65",    2, 8'h7F, 7'd65, 8'h7F);
        run_one("scale_c0_v16", 1, 8'hC0, 7'd16, 8'hF0);
        run_one("scale_01_v63", 1, 8'h01, 7'd63, 8'h00);
        run_one("scale_ff_v1",  1, 8'hFF, 7'd1,  8'hFF);
    endtask

    // rr_ptr is 2 here: the last grant was ch1.
    task automatic test_round_robin();
        set_chan(0, 8'h10, 7'd64);
        set_chan(3, 8'h20, 7'd64);
        step(1'b1, 1'b1, 4'h9);
        step(1'b1, 1'b1, 4'h0);   // grant should be ch3
        checks++;
        if (pending !== 4'h1) begin
            failures++;
            $display("FAIL rr_first_grant pending got=%h exp=1", pending);
        end
        step(1'b1, 1'b1, 4'h0);   // writeback ch3, grant ch0
        checks++;
        if (osample3 !== 8'h20 || osample0 !== 8'h00 || pending !== 4'h0) begin
            failures++;
            $display("FAIL rr_wb_ch3 got os3=%h os0=%h pending=%h exp 20/00/0",
                     osample3, osample0, pending);
        end
        step(1'b1, 1'b1, 4'h0);
        checks++;
        if (osample0 !== 8'h10 || out_strobe !== 1'b1) begin
            failures++;
            $display("FAIL rr_wb_ch0 got=%h strobe=%b exp=10 strobe=1", osample0, out_strobe);
        end
    endtask

    task automatic test_overrun();
        set_chan(2, 8'h11, 7'd64);
        step(1'b1, 1'b0, 4'h4);   // load without a tick
        checks++;
        if (pending !== 4'h4 || overrun !== 4'h0) begin
            failures++;
            $display("FAIL ovr_first_load got pending=%h overrun=%h exp 4/0", pending, overrun);
        end
        set_chan(2, 8'h22, 7'd64);
        step(1'b1, 1'b0, 4'h4);
        checks++;
        if (overrun !== 4'h4) begin
            failures++;
            $display("FAIL ovr_set got=%h exp=4", overrun);
        end
        step(1'b1, 1'b1, 4'h0);
        step(1'b1, 1'b1, 4'h0);
        checks++;
        if (osample2 !== 8'h22 || pending !== 4'h0 || overrun !== 4'h4) begin
            failures++;
            $display("FAIL ovr_wb got os2=%h pending=%h overrun=%h exp 22/0/4",
                     osample2, pending, overrun);
        end
        overrun_clr = 1'b1;
        step(1'b0, 1'b0, 4'h0);
        checks++;
        if (overrun !== 4'h0) begin
            failures++;
            $display("FAIL ovr_clear got=%h exp=0", overrun);
        end
        set_chan(2, 8'h33, 7'd64);
        step(1'b1, 1'b0, 4'h4);
        set_chan(2, 8'h44, 7'd64);
        overrun_clr = 1'b1;
        step(1'b1, 1'b0, 4'h4);
        checks++;
        if (overrun !== 4'h4) begin
            failures++;
            $display("FAIL ovr_set_wins got=%h exp=4", overrun);
        end
        overrun_clr = 1'b1;
        step(1'b1, 1'b1, 4'h0);
        step(1'b1, 1'b1, 4'h0);
        checks++;
        if (osample2 !== 8'h44 || overrun !== 4'h0) begin
            failures++;
            $display("FAIL ovr_second_wb got os2=%h overrun=%h exp 44/0", osample2, overrun);
        end
    endtask

    task automatic test_load_on_grant();
        set_chan(1, 8'h40, 7'd64);
        step(1'b1, 1'b1, 4'h2);
        set_chan(1, 8'h20, 7'd64);
        step(1'b1, 1'b1, 4'h2);   // grant ch1 with old values, reload
        checks++;
        if (pending !== 4'h2 || overrun !== 4'h0) begin
            failures++;
            $display("FAIL same_cycle_flags got pending=%h overrun=%h exp 2/0", pending, overrun);
        end
        step(1'b1, 1'b1, 4'h0);
        checks++;
        if (osample1 !== 8'h40) begin
            failures++;
            $display("FAIL same_cycle_old got=%h exp=40", osample1);
        end
        step(1'b1, 1'b1, 4'h0);
        checks++;
        if (osample1 !== 8'h20 || pending !== 4'h0) begin
            failures++;
            $display("FAIL same_cycle_new got=%h pending=%h exp 20/0", osample1, pending);
        end
    endtask

    task automatic test_reset_mid();
        int strobes;
        set_chan(1, 8'h60, 7'd64);
        step(1'b1, 1'b1, 4'h2);
        step(1'b1, 1'b1, 4'h0);   // ch1 granted, writeback not yet done
        reset_n = 1'b0;
        #1;
        checks++;
        if (osample1 !== 8'h00 || pending !== 4'h0 || out_strobe !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async got os1=%h pending=%h strobe=%b exp 00/0/0",
                     osample1, pending, out_strobe);
        end
        @(negedge clk);
        reset_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 4'h0);
            if (out_strobe) strobes++;
        end
        checks++;
        if (strobes != 0 || osample1 !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_discard got strobes=%0d os1=%h exp 0/00", strobes, osample1);
        end
        set_chan(2, 8'h08, 7'd64);
        step(1'b1, 1'b1, 4'h4);
        step(1'b1, 1'b1, 4'h0);
        checks++;
        if (osample2 !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_early got=%h exp=00", osample2);
        end
        step(1'b1, 1'b1, 4'h0);
        checks++;
        if (osample2 !== 8'h08 || out_strobe !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_resume got=%h strobe=%b exp=08 strobe=1", osample2, out_strobe);
        end
    endtask

    initial begin
        test_reset();
        test_load_all();
        test_scaling();
        test_round_robin();
        test_overrun();
        test_load_on_grant();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
